// File: rtl/motor_slew_pkg.sv
// Shared types and helpers for the motor slew-rate limiter.
// Commands are signed two's-complement, CMD_W bits wide.
package motor_slew_pkg;

  localparam int CMD_W  = 11;
  localparam int DIFF_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    ESTOP = 2'd2
  } state_e;

  // Symmetric saturation keeps -1024 out of the downstream magnitude path.
  function automatic logic signed [CMD_W-1:0] clamp_cmd(
    input logic signed [CMD_W-1:0] v,
    input int                      max_mag
  );
    int vi;
    vi = int'(v);
    if (vi > max_mag)       return CMD_W'(max_mag);
    else if (vi < -max_mag) return CMD_W'(-max_mag);
    else                    return v;
  endfunction

  function automatic logic [DIFF_W-1:0] abs_diff(input logic signed [DIFF_W-1:0] d);
    return d[DIFF_W-1] ? -d : d;
  endfunction

endpackage

// File: rtl/motor_slew_axis.sv
// One wheel of the slew limiter: target latch, current command register and
// the bounded-step datapath toward the latched target.
module slew_axis
  import motor_slew_pkg::*;
#(
  parameter int STEP    = 16,
  parameter int MAX_MAG = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic [CMD_W-1:0] tgt_in,
  output logic [CMD_W-1:0] cur,
  output logic             tgt_match,
  output logic             done
);

  localparam logic [DIFF_W-1:0]       STEP_MAG = DIFF_W'(STEP);
  localparam logic signed [CMD_W-1:0] STEP_CMD = CMD_W'(STEP);

  logic signed [CMD_W-1:0]  tgt_q, tgt_d;
  logic signed [CMD_W-1:0]  cur_q, cur_d;
  logic signed [CMD_W-1:0]  tgt_clamped;
  logic signed [CMD_W-1:0]  step_val;
  logic signed [DIFF_W-1:0] diff;
  logic [DIFF_W-1:0]        diff_mag;

  always_comb begin
    tgt_clamped = clamp_cmd($signed(tgt_in), MAX_MAG);
    // Extra bit so a full-scale reversal cannot overflow the difference.
    diff        = {tgt_q[CMD_W-1], tgt_q} - {cur_q[CMD_W-1], cur_q};
    diff_mag    = abs_diff(diff);

    if (diff_mag <= STEP_MAG)  step_val = tgt_q;
    else if (diff[DIFF_W-1])   step_val = cur_q - STEP_CMD;
    else                       step_val = cur_q + STEP_CMD;

    tgt_d = tgt_q;
    cur_d = cur_q;
    if (clear) begin
      tgt_d = '0;
      cur_d = '0;
    end else if (load) begin
      tgt_d = tgt_clamped;
    end else if (step) begin
      cur_d = step_val;
    end

    tgt_match = (tgt_clamped == cur_q);
    done      = (step_val == tgt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q <= '0;
      cur_q <= '0;
    end else begin
      tgt_q <= tgt_d;
      cur_q <= cur_d;
    end
  end

  assign cur = cur_q;

endmodule

// File: rtl/motor_slew.sv
// Slew-rate limiter ahead of the motor controller: ramps both wheel commands
// toward their targets one bounded step per prescaled tick, with e-stop.
module motor_slew
  import motor_slew_pkg::*;
#(
  parameter int STEP     = 16,
  parameter int TICK_DIV = 1024,
  parameter int MAX_MAG  = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] lft_tgt,
  input  logic [CMD_W-1:0] rht_tgt,
  input  logic             tgt_vld,
  input  logic             estop,
  output logic [CMD_W-1:0] lft,
  output logic [CMD_W-1:0] rht,
  output logic             at_tgt,
  output logic             ramping
);

  localparam int              CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_tgt_q, at_tgt_d;
  logic             ramping_q, ramping_d;
  logic             tick, accept, step;
  logic             l_match, r_match, l_done, r_done;

  always_comb begin
    tick   = (cnt_q == CNT_MAX);
    accept = tgt_vld && !estop && (state_q != ESTOP);
    // A target load on a tick cycle pre-empts that cycle's step.
    step   = (state_q == RAMP) && tick && !accept && !estop;
    cnt_d  = (accept || tick) ? '0 : cnt_q + 1'b1;

    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept && !(l_match && r_match)) state_d = RAMP;
      RAMP: begin
        if (accept)                        state_d = (l_match && r_match) ? IDLE : RAMP;
        else if (tick && l_done && r_done) state_d = IDLE;
      end
      ESTOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (estop) state_d = ESTOP;

    at_tgt_d  = (state_d == IDLE);
    ramping_d = (state_d == RAMP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      at_tgt_q  <= 1'b1;
      ramping_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      at_tgt_q  <= at_tgt_d;
      ramping_q <= ramping_d;
    end
  end

  slew_axis #(.STEP(STEP), .MAX_MAG(MAX_MAG)) u_lft (
    .clk       (clk),
    .rst       (rst),
    .clear     (estop),
    .load      (accept),
    .step      (step),
    .tgt_in    (lft_tgt),
    .cur       (lft),
    .tgt_match (l_match),
    .done      (l_done)
  );

  slew_axis #(.STEP(STEP), .MAX_MAG(MAX_MAG)) u_rht (
    .clk       (clk),
    .rst       (rst),
    .clear     (estop),
    .load      (accept),
    .step      (step),
    .tgt_in    (rht_tgt),
    .cur       (rht),
    .tgt_match (r_match),
    .done      (r_done)
  );

  assign at_tgt  = at_tgt_q;
  assign ramping = ramping_q;

endmodule

// File: doc/motor_slew.md
Name: motor_slew

Overview:
- Slew-rate limiter directly upstream of the motor controller; drives its signed 11-bit lft/rht duty commands.
- Accepts step-change wheel targets from the navigation/steering logic and ramps each wheel toward its target in bounded increments on a prescaled tick.
- Purpose: prevents current spikes and wheel slip on direction reversals.
- Includes an emergency-stop path that overrides ramping.

Parameters:
- STEP, 16, max magnitude change per wheel per tick (1..1023)
- TICK_DIV, 1024, clocks per ramp tick (>=2)
- MAX_MAG, 1023, saturation limit on target magnitude (<=1023)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous active-high reset
- lft_tgt  input  11  signed two's-complement left wheel target
- rht_tgt  input  11  signed two's-complement right wheel target
- tgt_vld  input  1  single-cycle strobe; latches lft_tgt/rht_tgt
- estop  input  1  level; forces outputs to zero while high
- lft  output  11  signed ramped left command to motor controller
- rht  output  11  signed ramped right command to motor controller
- at_tgt  output  1  high when both outputs equal latched targets and state is IDLE
- ramping  output  1  high in RAMP state

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. All outputs are registered.
- Reset values: lft=0, rht=0, latched targets=0, tick counter=0, state=IDLE, at_tgt=1, ramping=0.
- Reset asserted mid-ramp clears everything on the next edge; no partial step is taken.
- Target clamp on latch: values > MAX_MAG become MAX_MAG; values < -MAX_MAG become -MAX_MAG.
  - Consequence: -1024 latches as -1023. The downstream magnitude path cannot represent 1024.
- Tick counter: counts 0..TICK_DIV-1 and wraps; tick is asserted on the wrap cycle.
  - Cleared to 0 on every accepted tgt_vld.
  - First step therefore lands TICK_DIV cycles after acceptance.
- States: IDLE, RAMP, ESTOP.
  - IDLE: tgt_vld whose clamped target differs from the current output of either wheel -> RAMP.
  - IDLE: tgt_vld whose clamped target equals both current outputs -> stays IDLE; at_tgt stays 1.
  - RAMP: on each tick, each wheel steps independently.
    - diff = tgt - cur, computed 12-bit signed.
    - If |diff| <= STEP, cur <= tgt.
    - Otherwise cur <= cur + STEP*sign(diff).
  - RAMP: after a tick step leaves both wheels equal to target -> IDLE. at_tgt rises the same edge the outputs reach target.
  - RAMP: tgt_vld replaces the targets and clears the counter. Stepping continues from the current outputs; no jump occurs.
  - ESTOP: entered from any state when estop=1.
    - lft/rht and latched targets are 0 on the next edge.
    - at_tgt=0; ramping=0; tgt_vld is ignored.
  - ESTOP: estop deasserted -> IDLE with outputs 0 and at_tgt=1.
- Zero crossing needs no special handling. Steps pass through 0 and the sign changes naturally, which makes the downstream fwd/rev swap at most one step of magnitude.
- Simultaneous events:
  - estop and tgt_vld together: estop wins and the target is discarded.
  - tgt_vld on a tick cycle: the new target is latched, the counter clears, and no step is taken that cycle.
- Outputs never exceed ±MAX_MAG, and each output never moves more than STEP per tick.

Decomposition:
- Package motor_slew_pkg holds:
  - state enum (IDLE, RAMP, ESTOP)
  - CMD_W=11, DIFF_W=12
  - clamp and abs helper functions
- Sub-module slew_axis: one wheel. Contains the target latch, the current-value register, and the step/saturate datapath. It takes tick/load/clear inputs and produces cur and done.
  - Instantiated twice (left, right).
- Top level owns the prescaler and the FSM.

Test Plan:
All scenarios use STEP=16, TICK_DIV=4.
- Reset then idle: after rst, lft=rht=0, at_tgt=1, ramping=0.
- Basic ramp: tgt_vld with lft_tgt=100, rht_tgt=-50.
  - lft goes 16,32,48,64,80,96,100 on successive ticks; at_tgt=1 after the 7th tick (28 cycles after acceptance).
  - rht goes -16,-32,-48,-50 and holds from tick 4.
- Reversal: from lft=64, target -64 -> 48,32,16,0,-16,-32,-48,-64 over 8 ticks; never jumps more than 16.
- Clamp: lft_tgt=-1024, rht_tgt=1023 -> latched -1023/1023; final lft=-1023 and is never -1024.
- Estop mid-ramp: estop at lft=48 -> lft=rht=0 next edge, at_tgt=0.
  - A tgt_vld pulse asserted together with estop is ignored.
  - On release: IDLE, at_tgt=1.
- Retarget mid-ramp: at lft=32 (target 200), tgt_vld with 0 -> counter clears; lft=16 at 4 cycles, 0 at 8 cycles, then IDLE.
  - rst asserted during a further ramp returns all outputs to 0 on the next edge.
